// File: rtl/prim_ram_pkg.sv
// ---------------------------------------------------------------------------
// prim_ram_pkg: shared types and helpers for the 1R1W init RAM primitive.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package prim_ram_pkg;

  typedef enum logic [0:0] {
    RamInit  = 1'b0,
    RamReady = 1'b1
  } ram_init_state_e;

  // Number of write-enable groups for a given data width and group size.
  function automatic int mask_width(input int width, input int bits_per_mask);
    return width / bits_per_mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prim_ram_1r1w_array.sv
// ---------------------------------------------------------------------------
// prim_ram_1r1w_array: bare masked 1R1W storage, no reset (SRAM macro swap point).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prim_ram_1r1w_array
  import prim_ram_pkg::*;
#(
  parameter int Width           = 32,
  parameter int Depth           = 128,
  parameter int DataBitsPerMask = 1,
  localparam int Aw             = $clog2(Depth),
  localparam int MaskW          = mask_width(Width, DataBitsPerMask)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [Aw-1:0]    waddr,
  input  logic [Width-1:0] wdata,
  input  logic [MaskW-1:0] wmask,
  input  logic             re,
  input  logic [Aw-1:0]    raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [Depth];

  // Read returns the pre-write contents; the caller handles write-first bypass.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int g = 0; g < MaskW; g++) begin
        if (wmask[g]) begin
          mem[waddr][g*DataBitsPerMask +: DataBitsPerMask] <=
            wdata[g*DataBitsPerMask +: DataBitsPerMask];
        end
      end
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/prim_ram_1r1w_init.sv
// ---------------------------------------------------------------------------
// prim_ram_1r1w_init: 1R1W SRAM with hardware clear engine, masked writes and bypass.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prim_ram_1r1w_init
  import prim_ram_pkg::*;
#(
  parameter int               Width           = 32,
  parameter int               Depth           = 128,
  parameter int               DataBitsPerMask = 1,
  parameter int               OutputReg       = 0,
  parameter logic [Width-1:0] InitValue       = '0,
  localparam int              Aw              = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             init_i,
  output logic             init_done_o,
  input  logic             wreq_i,
  output logic             wgnt_o,
  input  logic [Aw-1:0]    waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [Width-1:0] wmask_i,
  input  logic             rreq_i,
  output logic             rgnt_o,
  input  logic [Aw-1:0]    raddr_i,
  output logic [Width-1:0] rdata_o,
  output logic             rvalid_o
);

  localparam int            MaskW    = mask_width(Width, DataBitsPerMask);
  localparam logic [31:0]   DepthW   = 32'(Depth);
  localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);

  ram_init_state_e state;
  logic [Aw-1:0]   init_cnt;
  logic            ready;
  logic            waddr_ok;
  logic            raddr_ok;
  logic [MaskW-1:0] wgroup;

  assign ready       = (state == RamReady);
  assign init_done_o = ready;
  assign wgnt_o      = wreq_i & ready & ~init_i;
  assign rgnt_o      = rreq_i & ready & ~init_i;
  assign waddr_ok    = (32'(waddr_i) < DepthW);
  assign raddr_ok    = (32'(raddr_i) < DepthW);

  // A group is written only when every mask bit inside it is set.
  always_comb begin
    wgroup = '0;
    for (int g = 0; g < MaskW; g++) begin
      wgroup[g] = &wmask_i[g*DataBitsPerMask +: DataBitsPerMask];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= RamInit;
      init_cnt <= '0;
    end else begin
      case (state)
        RamInit: begin
          if (init_cnt == LastAddr) begin
            state    <= RamReady;
            init_cnt <= '0;
          end else begin
            init_cnt <= init_cnt + Aw'(1);
          end
        end
        RamReady: begin
          if (init_i) begin
            state    <= RamInit;
            init_cnt <= '0;
          end
        end
        default: begin
          state    <= RamInit;
          init_cnt <= '0;
        end
      endcase
    end
  end

  logic             arr_we;
  logic [Aw-1:0]    arr_waddr;
  logic [Width-1:0] arr_wdata;
  logic [MaskW-1:0] arr_wmask;
  logic             arr_re;
  logic [Width-1:0] arr_rdata;

  // Clear engine owns the write port while initialising; grants are low then.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = waddr_i;
    arr_wdata = wdata_i;
    arr_wmask = wgroup;
    if (state == RamInit) begin
      arr_we    = 1'b1;
      arr_waddr = init_cnt;
      arr_wdata = InitValue;
      arr_wmask = '1;
    end else if (wgnt_o && waddr_ok) begin
      arr_we = 1'b1;
    end
  end

  assign arr_re = rgnt_o & raddr_ok;

  prim_ram_1r1w_array #(
    .Width           (Width),
    .Depth           (Depth),
    .DataBitsPerMask (DataBitsPerMask)
  ) u_array (
    .clk   (clk_i),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .wmask (arr_wmask),
    .re    (arr_re),
    .raddr (raddr_i),
    .rdata (arr_rdata)
  );

  logic             rd_valid;
  logic             rd_loaded;
  logic             rd_oob;
  logic [MaskW-1:0] rd_byp;
  logic [Width-1:0] rd_wdata;
  logic [Width-1:0] rd_merged;

  // Bypass context is captured only on a granted read so the result holds afterwards.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_valid  <= 1'b0;
      rd_loaded <= 1'b0;
      rd_oob    <= 1'b0;
      rd_byp    <= '0;
      rd_wdata  <= '0;
    end else begin
      rd_valid <= rgnt_o;
      if (rgnt_o) begin
        rd_loaded <= 1'b1;
        rd_oob    <= ~raddr_ok;
        rd_byp    <= (wgnt_o && (waddr_i == raddr_i)) ? wgroup : '0;
        rd_wdata  <= wdata_i;
      end
    end
  end

  always_comb begin
    rd_merged = '0;
    if (rd_loaded && !rd_oob) begin
      for (int g = 0; g < MaskW; g++) begin
        rd_merged[g*DataBitsPerMask +: DataBitsPerMask] = rd_byp[g] ?
          rd_wdata[g*DataBitsPerMask +: DataBitsPerMask] :
          arr_rdata[g*DataBitsPerMask +: DataBitsPerMask];
      end
    end
  end

  if (OutputReg != 0) begin : g_out_reg
    logic             out_valid;
    logic [Width-1:0] out_data;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        out_valid <= 1'b0;
        out_data  <= '0;
      end else begin
        out_valid <= rd_valid;
        if (rd_valid) begin
          out_data <= rd_merged;
        end
      end
    end

    assign rvalid_o = out_valid;
    assign rdata_o  = out_data;
  end else begin : g_out_comb
    assign rvalid_o = rd_valid;
    assign rdata_o  = rd_merged;
  end

endmodule

`default_nettype wire
